// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver that turns host keystrokes into held move commands
// and single-cycle start / game-reset requests.
module uart_cmd_rx #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned HOLD_CLKS    = 2500000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_UART_RX,
    output logic       o_Up,
    output logic       o_Dn,
    output logic       o_Lt,
    output logic       o_Rt,
    output logic       o_Start,
    output logic       o_Reset_Game,
    output logic [7:0] o_Byte,
    output logic       o_Byte_Valid,
    output logic       o_Frame_Err
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned HOLD_W = 22;
    localparam int unsigned HALF   = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(HALF);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CLKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    state_e            state_q, state_d;
    logic              rx_meta_q, rx_meta_d;
    logic              rx_q, rx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        byte_q, byte_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              start_q, start_d;
    logic              rstg_q, rstg_d;
    logic [3:0]        move_q, move_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic       frame_ok;
    logic [3:0] cmd_move;
    logic       cmd_start;
    logic       cmd_reset;

    // Key decode of the byte that has just been fully shifted in
    always_comb begin
        cmd_move  = 4'b0000;
        cmd_start = 1'b0;
        cmd_reset = 1'b0;
        case (shift_q)
            8'h77, 8'h57: cmd_move = 4'b0001;
            8'h73, 8'h53: cmd_move = 4'b0010;
            8'h61, 8'h41: cmd_move = 4'b0100;
            8'h64, 8'h44: cmd_move = 4'b1000;
            8'h20:        cmd_start = 1'b1;
            8'h72, 8'h52: cmd_reset = 1'b1;
            default:      cmd_move = 4'b0000;
        endcase
    end

    // Receive FSM, output pulses and move-hold timer
    always_comb begin
        state_d   = state_q;
        rx_meta_d = i_UART_RX;
        rx_d      = rx_meta_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        start_d   = 1'b0;
        rstg_d    = 1'b0;
        move_d    = move_q;
        hold_d    = hold_q;
        frame_ok  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                // The IDLE cycle that saw rx low already counts toward the start-bit midpoint
                if (!rx_q) begin
                    state_d = ST_START;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                    frame_ok = rx_q;
                    ferr_d   = ~rx_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        if (frame_ok) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            start_d = cmd_start;
            rstg_d  = cmd_reset;
        end

        // Game reset drops any held move; a new move always restarts the full hold
        if (frame_ok && cmd_reset) begin
            move_d = 4'b0000;
            hold_d = '0;
        end else if (frame_ok && (cmd_move != 4'b0000)) begin
            move_d = cmd_move;
            hold_d = HOLD_LOAD;
        end else if (move_q != 4'b0000) begin
            if (hold_q == '0) begin
                move_d = 4'b0000;
            end else begin
                hold_d = hold_q - HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= ST_IDLE;
            rx_meta_q <= 1'b1;
            rx_q      <= 1'b1;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            start_q   <= 1'b0;
            rstg_q    <= 1'b0;
            move_q    <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_meta_d;
            rx_q      <= rx_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            start_q   <= start_d;
            rstg_q    <= rstg_d;
            move_q    <= move_d;
            hold_q    <= hold_d;
        end
    end

    assign o_Up         = move_q[0];
    assign o_Dn         = move_q[1];
    assign o_Lt         = move_q[2];
    assign o_Rt         = move_q[3];
    assign o_Start      = start_q;
    assign o_Reset_Game = rstg_q;
    assign o_Byte       = byte_q;
    assign o_Byte_Valid = valid_q;
    assign o_Frame_Err  = ferr_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: two instances (short and long hold) share one serial line
// and are compared every cycle against a frame-level model of the key protocol.
module tb_uart_cmd_rx;

    localparam int unsigned CPB    = 4;
    localparam int unsigned HOLD_S = 10;
    localparam int unsigned HOLD_L = 60;
    localparam int unsigned H      = (CPB - 1) / 2;
    // cycles from driving the start bit to the cycle o_Byte_Valid is high
    localparam int unsigned LAT    = 3 + H + 9 * CPB;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx    = 1'b1;

    logic [1:0]  vld, ferr, st, rg;
    logic [7:0]  mv;
    logic [15:0] byt;

    uart_cmd_rx #(.CLKS_PER_BIT(CPB), .HOLD_CLKS(HOLD_S)) u_dut_s (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_UART_RX(rx),
        .o_Up(mv[0]), .o_Dn(mv[1]), .o_Lt(mv[2]), .o_Rt(mv[3]),
        .o_Start(st[0]), .o_Reset_Game(rg[0]), .o_Byte(byt[7:0]),
        .o_Byte_Valid(vld[0]), .o_Frame_Err(ferr[0])
    );

    uart_cmd_rx #(.CLKS_PER_BIT(CPB), .HOLD_CLKS(HOLD_L)) u_dut_l (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_UART_RX(rx),
        .o_Up(mv[4]), .o_Dn(mv[5]), .o_Lt(mv[6]), .o_Rt(mv[7]),
        .o_Start(st[1]), .o_Reset_Game(rg[1]), .o_Byte(byt[15:8]),
        .o_Byte_Valid(vld[1]), .o_Frame_Err(ferr[1])
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d t=%0t got=%0h expected=%0h", nm, inst, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned at;
        logic [7:0]  b;
        bit          ok;
    } ev_t;

    ev_t         evq[$];
    ev_t         ev;
    int unsigned cyc = 0;
    logic [7:0]  m_byte;
    bit          m_vld, m_ferr, m_start, m_rg;
    int unsigned m_rem[2];
    int          m_dir[2];
    int          d;
    logic [3:0]  m_mv;

    function automatic int dir_of(input logic [7:0] b);
        if (b == 8'h77 || b == 8'h57) return 0;
        if (b == 8'h73 || b == 8'h53) return 1;
        if (b == 8'h61 || b == 8'h41) return 2;
        if (b == 8'h64 || b == 8'h44) return 3;
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        m_vld   = 1'b0;
        m_ferr  = 1'b0;
        m_start = 1'b0;
        m_rg    = 1'b0;
        if (!rst_n) begin
            m_byte = 8'h00;
            m_rem  = '{0, 0};
            m_dir  = '{0, 0};
            evq.delete();
        end else begin
            for (int i = 0; i < 2; i++) if (m_rem[i] > 0) m_rem[i]--;
            if (evq.size() != 0 && evq[0].at == cyc) begin
                ev = evq.pop_front();
                if (!ev.ok) begin
                    m_ferr = 1'b1;
                end else begin
                    m_vld  = 1'b1;
                    m_byte = ev.b;
                    d      = dir_of(ev.b);
                    m_start = (ev.b == 8'h20);
                    if (ev.b == 8'h72 || ev.b == 8'h52) begin
                        m_rg  = 1'b1;
                        m_rem = '{0, 0};
                    end
                    if (d >= 0) begin
                        m_rem = '{HOLD_S, HOLD_L};
                        m_dir = '{d, d};
                    end
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            m_mv = (m_rem[i] > 0) ? 4'(1 << m_dir[i]) : 4'b0000;
            chk("byte_valid", i, 32'(vld[i]), 32'(m_vld));
            chk("frame_err", i, 32'(ferr[i]), 32'(m_ferr));
            chk("start", i, 32'(st[i]), 32'(m_start));
            chk("reset_game", i, 32'(rg[i]), 32'(m_rg));
            chk("byte", i, 32'(byt[i*8 +: 8]), 32'(m_byte));
            chk("moves", i, 32'(mv[i*4 +: 4]), 32'(m_mv));
        end
    end

    // ---------------- event counters for directed literal checks ----------------
    int n_vld[2], n_ferr[2], n_st[2], n_rg[2];
    int n_mv[2][4];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            n_vld[i]  += int'(vld[i]);
            n_ferr[i] += int'(ferr[i]);
            n_st[i]   += int'(st[i]);
            n_rg[i]   += int'(rg[i]);
            for (int j = 0; j < 4; j++) n_mv[i][j] += int'(mv[i*4 + j]);
        end
    end

    task automatic clr_counts();
        for (int i = 0; i < 2; i++) begin
            n_vld[i] = 0; n_ferr[i] = 0; n_st[i] = 0; n_rg[i] = 0;
            for (int j = 0; j < 4; j++) n_mv[i][j] = 0;
        end
    endtask

    // ---------------- stimulus (all tasks start and end at posedge+1) ----------------
    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        evq.push_back('{at: cyc + LAT, b: b, ok: stop_ok});
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < CPB; c++) begin
                // a bad stop bit is low across its sample point, then the line recovers
                if (i == 9 && !stop_ok) rx = (c <= int'(H)) ? 1'b0 : 1'b1;
                else                    rx = bits[i];
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic glitch();
        rx = 1'b0;
        @(posedge clk); #1;
        idle(3);
    endtask

    logic [7:0] keys [12] = '{8'h77, 8'h57, 8'h73, 8'h53, 8'h61, 8'h41,
                              8'h64, 8'h44, 8'h20, 8'h72, 8'h52, 8'h2e};

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] bits;
        logic [7:0] b;
        clr_counts();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_byte", 0, 32'(byt), 32'h0);
        chk("reset_moves", 0, 32'(mv), 32'h0);
        idle(3);

        // 1: 'w'
        clr_counts();
        send_frame(8'h77, 1'b1);
        idle(15);
        chk("t1_valid_count", 0, n_vld[0], 1);
        chk("t1_byte", 0, 32'(byt[7:0]), 32'h77);
        chk("t1_up_cycles", 0, n_mv[0][0], 10);
        chk("t1_other_moves", 0, n_mv[0][1] + n_mv[0][2] + n_mv[0][3], 0);
        chk("t1_ferr", 0, n_ferr[0], 0);
        idle(50);
        chk("t1_up_cycles_long", 1, n_mv[1][0], 60);

        // 2: 'a' then 'D' back-to-back
        clr_counts();
        send_frame(8'h61, 1'b1);
        send_frame(8'h44, 1'b1);
        idle(65);
        chk("t2_lt_short", 0, n_mv[0][2], 10);
        chk("t2_rt_short", 0, n_mv[0][3], 10);
        chk("t2_lt_long", 1, n_mv[1][2], 40);
        chk("t2_rt_long", 1, n_mv[1][3], 60);

        // 3: space then 'R'
        clr_counts();
        send_frame(8'h20, 1'b1);
        send_frame(8'h52, 1'b1);
        idle(5);
        chk("t3_start", 0, n_st[0], 1);
        chk("t3_reset_game", 0, n_rg[0], 1);
        chk("t3_valid_count", 0, n_vld[0], 2);
        chk("t3_byte", 0, 32'(byt[7:0]), 32'h52);
        chk("t3_moves", 0, n_mv[0][0] + n_mv[0][1] + n_mv[0][2] + n_mv[0][3], 0);

        // 4: 's' with bad stop bit
        clr_counts();
        send_frame(8'h73, 1'b0);
        idle(5);
        chk("t4_ferr", 0, n_ferr[0], 1);
        chk("t4_valid_count", 0, n_vld[0], 0);
        chk("t4_byte_kept", 0, 32'(byt[7:0]), 32'h52);
        chk("t4_dn", 0, n_mv[0][1], 0);

        // 5: glitch then 'd'
        clr_counts();
        glitch();
        idle(3);
        chk("t5_glitch_quiet", 0, n_vld[0] + n_ferr[0], 0);
        send_frame(8'h64, 1'b1);
        idle(15);
        chk("t5_valid_count", 0, n_vld[0], 1);
        chk("t5_rt_cycles", 0, n_mv[0][3], 10);

        // 6: reset during data bit 4 of 'w' while Lt is held
        send_frame(8'h61, 1'b1);
        bits = {1'b1, 8'h77, 1'b0};
        for (int i = 0; i < 4 * int'(CPB) + int'(CPB) + 2; i++) begin
            rx = bits[i / int'(CPB)];
            @(posedge clk); #1;
        end
        chk("t6_lt_held", 1, 32'(mv[6]), 32'h1);
        #2 rst_n = 1'b0;
        rx = 1'b1;
        #1;
        chk("t6_async_moves", 0, 32'(mv), 32'h0);
        chk("t6_async_byte", 0, 32'(byt), 32'h0);
        chk("t6_async_pulses", 0, 32'({vld, ferr, st, rg}), 32'h0);
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        clr_counts();
        idle(3);
        send_frame(8'h41, 1'b1);
        idle(15);
        chk("t6_valid_count", 0, n_vld[0], 1);
        chk("t6_byte", 0, 32'(byt[7:0]), 32'h41);
        chk("t6_lt_cycles", 0, n_mv[0][2], 10);
        chk("t6_ferr", 0, n_ferr[0], 0);
        idle(50);

        // randomized traffic
        for (int k = 0; k < 100; k++) begin
            if ($urandom_range(0, 99) < 70) b = keys[$urandom_range(0, 11)];
            else                            b = 8'($urandom);
            if ($urandom_range(0, 9) == 0) glitch();
            send_frame(b, $urandom_range(0, 9) != 0);
            idle(int'($urandom_range(0, 6)));
        end
        idle(70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
